// File: rtl/data_port_arbiter.sv
// data_port_arbiter: two-master arbiter for one shared split-transaction data port.
// Define ARB_STARVE_GUARD_EN to let a starving m1 be forced through after STARVE_LIMIT m0 wins.
module data_port_arbiter #(
    parameter int OT_DEPTH     = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m0_req,
    input  logic [71:0] m0_cmd,
    output logic        m0_addr_ok,
    output logic        m0_data_ok,
    input  logic        m1_req,
    input  logic [71:0] m1_cmd,
    output logic        m1_addr_ok,
    output logic        m1_data_ok,
    output logic        data_req,
    output logic [71:0] data_cmd,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    output logic        busy,
    output logic        resp_err
);
    localparam int PW = $clog2(OT_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] LOCK = 1'b1;

    logic [0:0]          state;
    logic                lock_id;
    logic [OT_DEPTH-1:0] ids;
    logic [PW-1:0]       wp;
    logic [PW-1:0]       rp;
    logic [CW-1:0]       count;
    logic                grant_id;
    logic                grant_req;
    logic                full;
    logic                push;
    logic                pop;
    logic                head;
    logic                force_m1;

`ifdef ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] starve_cnt;

    assign force_m1 = m1_req && starve_cnt == SW'(STARVE_LIMIT);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            starve_cnt <= '0;
        else if (!m1_req || grant_id)
            starve_cnt <= '0;
        else if (state == IDLE && m0_req)
            starve_cnt <= starve_cnt + SW'(1);
    end
`else
    assign force_m1 = 1'b0;
`endif

    // grant_id may read 1 with no request pending; grant_req then masks it
    assign grant_id   = (state == LOCK) ? lock_id : (force_m1 || !m0_req);
    assign grant_req  = grant_id ? m1_req : m0_req;
    assign full       = count == CW'(OT_DEPTH);
    assign data_req   = resetn && grant_req && !full;
    assign data_cmd   = (resetn && grant_req) ? (grant_id ? m1_cmd : m0_cmd) : '0;
    assign push       = data_req && data_addr_ok;
    assign m0_addr_ok = push && !grant_id;
    assign m1_addr_ok = push && grant_id;
    assign pop        = resetn && data_data_ok && count != '0;
    assign head       = ids[rp];
    assign m0_data_ok = pop && !head;
    assign m1_data_ok = pop && head;
    assign busy       = count != '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            lock_id <= 1'b0;
        end else if (state == IDLE && data_req && !data_addr_ok) begin
            state   <= LOCK;
            lock_id <= grant_id;
        end else if (state == LOCK && (!grant_req || push)) begin
            state   <= IDLE;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            resp_err <= 1'b0;
        end else begin
            wp       <= push ? wp + PW'(1) : wp;
            rp       <= pop ? rp + PW'(1) : rp;
            count    <= count + CW'(push) - CW'(pop);
            resp_err <= resp_err || (data_data_ok && count == '0);
        end
    end

    // order entries need no reset: count gates every read
    always_ff @(posedge clk) begin
        if (push)
            ids[wp] <= grant_id;
    end
endmodule

// File: tb/tb_data_port_arbiter.sv
// tb_data_port_arbiter: directed scenarios with a response-order scoreboard.
module tb_data_port_arbiter;
    logic        clk = 1'b0;
    logic        resetn;
    logic        m0_req, m1_req, data_addr_ok, data_data_ok;
    logic [71:0] m0_cmd, m1_cmd, data_cmd;
    logic        m0_addr_ok, m0_data_ok, m1_addr_ok, m1_data_ok;
    logic        data_req, busy, resp_err;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic        sb[$];

    localparam logic [71:0] C0 = {1'b1, 3'd2, 4'hf, 32'h1000_0040, 32'hdead_beef};
    localparam logic [71:0] C1 = {1'b0, 3'd1, 4'h3, 32'h2000_0008, 32'h0bad_f00d};

    data_port_arbiter dut (
        .clk(clk), .resetn(resetn),
        .m0_req(m0_req), .m0_cmd(m0_cmd), .m0_addr_ok(m0_addr_ok), .m0_data_ok(m0_data_ok),
        .m1_req(m1_req), .m1_cmd(m1_cmd), .m1_addr_ok(m1_addr_ok), .m1_data_ok(m1_data_ok),
        .data_req(data_req), .data_cmd(data_cmd), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .busy(busy), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"}, data_req, 0);
        chk({tag, "_cmd"}, data_cmd, 0);
        chk({tag, "_aok"}, {m0_addr_ok, m1_addr_ok}, 0);
        chk({tag, "_dok"}, {m0_data_ok, m1_data_ok}, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"}, resp_err, 0);
    endtask

    // drive at negedge, sample 1ns later; pops checked before pushes are recorded
    task automatic cyc(input string tag, input logic r0, r1, ao, dok, e0, e1);
        logic id;
        @(negedge clk);
        m0_req = r0; m1_req = r1; data_addr_ok = ao; data_data_ok = dok;
        #1;
        if (dok && sb.size() > 0) begin
            id = sb.pop_front();
            chk({tag, "_d0"}, m0_data_ok, !id);
            chk({tag, "_d1"}, m1_data_ok, id);
        end else begin
            chk({tag, "_d0"}, m0_data_ok, 0);
            chk({tag, "_d1"}, m1_data_ok, 0);
        end
        chk({tag, "_a0"}, m0_addr_ok, e0);
        chk({tag, "_a1"}, m1_addr_ok, e1);
        if (e0) sb.push_back(1'b0);
        if (e1) sb.push_back(1'b1);
    endtask

    initial begin
        m0_cmd = C0; m1_cmd = C1;
        resetn = 1'b0; m0_req = 1'b1; m1_req = 1'b1; data_addr_ok = 1'b1; data_data_ok = 1'b1;
        @(negedge clk); @(negedge clk); #1;
        chk_all_zero("rst");
        @(negedge clk);
        resetn = 1'b1; m0_req = 0; m1_req = 0; data_addr_ok = 0; data_data_ok = 0;

        cyc("a", 1, 1, 1, 0, 1, 0);
        chk("a_cmd", data_cmd, C0);
        chk("a_req", data_req, 1);
        cyc("b", 0, 1, 0, 1, 0, 0);
        chk("b_cmd", data_cmd, C1);
        chk("b_busy", busy, 1);
        cyc("c", 1, 1, 0, 0, 0, 0);
        chk("c_cmd", data_cmd, C1);
        cyc("d", 1, 1, 0, 0, 0, 0);
        chk("d_cmd", data_cmd, C1);
        cyc("e", 1, 1, 1, 0, 0, 1);
        cyc("f", 1, 0, 1, 0, 1, 0);
        cyc("g", 0, 1, 1, 0, 0, 1);
        cyc("h", 1, 0, 1, 0, 1, 0);
        cyc("i", 1, 1, 1, 0, 0, 0);
        chk("i_full_req", data_req, 0);
        chk("i_busy", busy, 1);
        cyc("j", 1, 1, 1, 1, 0, 0);
        chk("j_full_req", data_req, 0);
        cyc("k", 1, 1, 1, 0, 1, 0);
        chk("k_req", data_req, 1);
        for (int i = 0; i < 4; i++) begin
            cyc("drain", 0, 0, 0, 1, 0, 0);
            chk("drain_cmd", data_cmd, 0);
            chk("drain_req", data_req, 0);
        end
        cyc("p", 0, 0, 0, 0, 0, 0);
        chk("p_busy", busy, 0);
        chk("p_err", resp_err, 0);
        cyc("q", 0, 0, 0, 1, 0, 0);
        cyc("r", 0, 0, 0, 0, 0, 0);
        chk("r_err", resp_err, 1);
        chk("r_busy", busy, 0);

        cyc("s", 1, 0, 0, 0, 0, 0);
        chk("s_req", data_req, 1);
        cyc("t", 0, 1, 0, 0, 0, 0);
        chk("t_drop_req", data_req, 0);
        cyc("u", 0, 1, 1, 0, 0, 1);
        chk("u_err_sticky", resp_err, 1);
        cyc("v", 1, 0, 0, 0, 0, 0);
        chk("v_busy", busy, 1);

        #2 resetn = 1'b0;
        #1 chk_all_zero("arst");
        sb.delete();
        @(negedge clk);
        resetn = 1'b1; m0_req = 0; m1_req = 0; data_addr_ok = 0; data_data_ok = 0;
        cyc("w", 0, 0, 0, 0, 0, 0);
        chk("w_busy", busy, 0);
        cyc("x", 0, 0, 0, 1, 0, 0);

        for (int k = 1; k <= 12; k++) begin
`ifdef ARB_STARVE_GUARD_EN
            cyc("starve", 1, 1, 1, k > 1, k != 9, k == 9);
`else
            cyc("starve", 1, 1, 1, k > 1, 1, 0);
`endif
        end
        cyc("y", 0, 0, 0, 1, 0, 0);
        cyc("z", 0, 0, 0, 0, 0, 0);
        chk("z_busy", busy, 0);
        chk("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
